// File: rtl/cmd_proc_q_pkg.sv
// Shared opcodes, executor states and response codes for the queued command processor.
package cmd_proc_q_pkg;

    typedef enum logic [3:0] {
        OP_CAL     = 4'h0,
        OP_MOVE    = 4'h2,
        OP_MOVE_FF = 4'h3,
        OP_TOUR    = 4'h4,
        OP_ABORT   = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        CAL,
        ALIGN,
        RAMP,
        CRUISE,
        DECEL,
        DONE
    } state_e;

    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] ABORTED = 8'h5A;
    localparam logic [7:0] NACK    = 8'hEE;

    function automatic logic [11:0] sat12(input logic signed [12:0] v);
        if (v > 13'sd2047)
            return 12'h7FF;
        else if (v < -13'sd2048)
            return 12'h800;
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/cmd_proc_q_if.sv
// UART-side command/response handshake: master is the UART wrapper, slave is the processor.
interface cmd_proc_q_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (output cmd, cmd_rdy, input clr_cmd_rdy, send_resp, resp);
    modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, send_resp, resp);
endinterface

// File: rtl/cmd_proc_q_fifo.sv
// Show-ahead FIFO: head word is visible on pop_dat, pop retires it; writes land one clk after push.
// Push when full and pop when empty are ignored; flush empties the queue in one clk.
module cmd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cmd_proc_q.sv
// Knight-robot command processor: queued intake, calibrate/move/tour executor; pulse outputs are registered (1 clk).
// Full queue withholds clr_cmd_rdy so cmd_rdy stays high; abort bypasses the queue and flushes it.
module cmd_proc_q
    import cmd_proc_q_pkg::*;
#(
    parameter bit                 FAST_SIM = 1'b1,
    parameter int                 FRWRD_W  = 10,
    parameter logic [FRWRD_W-1:0] MAX_SPD  = 'h300,
    parameter int                 QDEPTH   = 4,
    parameter logic [11:0]        ERR_THR  = 12'h030,
    parameter logic [11:0]        NUDGE    = 12'h05F
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cmd_proc_q_if.slave                  uart,
    output logic                         strt_cal,
    input  logic                         cal_done,
    input  logic [11:0]                  heading,
    input  logic                         heading_rdy,
    input  logic                         lftIR,
    input  logic                         rghtIR,
    input  logic                         cntrIR,
    output logic [11:0]                  error,
    output logic [FRWRD_W-1:0]           frwrd,
    output logic                         moving,
    output logic                         tour_go,
    output logic                         fanfare_go,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);
    localparam logic [FRWRD_W-1:0] INC  = FAST_SIM ? FRWRD_W'(32'h20) : FRWRD_W'(32'h04);
    localparam logic [FRWRD_W-1:0] INC2 = INC << 1;

    state_e              state, state_nxt;
    logic [15:0]         head;
    logic                full, empty, take, push, pop, abort_in;
    logic                abort_pend, clr_pend, start_move;
    logic [11:0]         desired;
    logic [3:0]          sq;
    logic                ff_move;
    logic [4:0]          line_cnt;
    logic [2:0]          ir_sync;
    logic                ir_rise, counting, hit, aligned;
    logic [FRWRD_W-1:0]  frwrd_nxt, ramp_up, ramp_dn;
    logic [FRWRD_W:0]    up_sum;
    logic [11:0]         diff;
    logic signed [12:0]  err_sum;
    logic [12:0]         err_ext, err_abs;
    logic                clr_q, send_q, send_nxt, strt_nxt, tour_nxt, fan_nxt;
    logic [7:0]          resp_q, resp_nxt;

    // clr_q masks the cycle in which the wrapper is still dropping cmd_rdy
    assign take     = uart.cmd_rdy & ~clr_q;
    assign abort_in = take & (uart.cmd[15:12] == OP_ABORT);
    assign push     = take & ~abort_in & ~full;

    cmd_fifo #(.W(16), .DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (uart.cmd),
        .pop      (pop),
        .pop_dat  (head),
        .flush    (abort_in),
        .count    (q_count),
        .full     (full),
        .empty    (empty)
    );

    assign diff = heading - desired;
    always_comb begin
        err_sum = $signed({diff[11], diff});
        if (lftIR && !rghtIR)
            err_sum = err_sum + $signed({1'b0, NUDGE});
        else if (rghtIR && !lftIR)
            err_sum = err_sum - $signed({1'b0, NUDGE});
    end
    assign error   = sat12(err_sum);
    assign err_ext = {error[11], error};
    assign err_abs = error[11] ? (~err_ext + 13'd1) : err_ext;
    assign aligned = err_abs < {1'b0, ERR_THR};

    assign up_sum  = {1'b0, frwrd} + {1'b0, INC};
    assign ramp_up = (up_sum >= {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[FRWRD_W-1:0];
    assign ramp_dn = (frwrd > INC2) ? (frwrd - INC2) : '0;

    assign ir_rise  = ir_sync[1] & ~ir_sync[2];
    assign counting = (state == ALIGN) || (state == RAMP) || (state == CRUISE);
    assign hit      = line_cnt >= {sq, 1'b0};
    assign moving   = counting || (state == DECEL);

    assign uart.clr_cmd_rdy = clr_q;
    assign uart.send_resp   = send_q;
    assign uart.resp        = resp_q;

    always_comb begin
        state_nxt  = state;
        frwrd_nxt  = frwrd;
        pop        = 1'b0;
        send_nxt   = 1'b0;
        resp_nxt   = resp_q;
        strt_nxt   = 1'b0;
        tour_nxt   = 1'b0;
        fan_nxt    = 1'b0;
        clr_pend   = 1'b0;
        start_move = 1'b0;
        case (state)
            IDLE: begin
                if (abort_pend) begin
                    send_nxt = 1'b1;
                    resp_nxt = ABORTED;
                    clr_pend = 1'b1;
                end else if (!abort_in && !empty) begin
                    pop = 1'b1;
                    case (head[15:12])
                        OP_CAL: begin
                            strt_nxt  = 1'b1;
                            state_nxt = CAL;
                        end
                        OP_MOVE, OP_MOVE_FF: begin
                            start_move = 1'b1;
                            state_nxt  = ALIGN;
                        end
                        OP_TOUR: tour_nxt = 1'b1;
                        default: begin
                            send_nxt = 1'b1;
                            resp_nxt = NACK;
                        end
                    endcase
                end
            end
            CAL: begin
                if (cal_done) begin
                    send_nxt  = 1'b1;
                    resp_nxt  = abort_pend ? ABORTED : ACK;
                    clr_pend  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ALIGN: begin
                if (abort_pend || sq == 4'h0)
                    state_nxt = DECEL;
                else if (heading_rdy && aligned)
                    state_nxt = RAMP;
            end
            RAMP: begin
                if (abort_pend || hit)
                    state_nxt = DECEL;
                else if (heading_rdy) begin
                    frwrd_nxt = ramp_up;
                    if (ramp_up == MAX_SPD)
                        state_nxt = CRUISE;
                end
            end
            CRUISE: begin
                if (abort_pend || hit)
                    state_nxt = DECEL;
            end
            DECEL: begin
                if (frwrd == '0)
                    state_nxt = DONE;
                else if (heading_rdy)
                    frwrd_nxt = ramp_dn;
            end
            DONE: begin
                send_nxt  = 1'b1;
                resp_nxt  = abort_pend ? ABORTED : ACK;
                fan_nxt   = ff_move & ~abort_pend;
                clr_pend  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frwrd      <= '0;
            clr_q      <= 1'b0;
            send_q     <= 1'b0;
            resp_q     <= 8'h00;
            strt_cal   <= 1'b0;
            tour_go    <= 1'b0;
            fanfare_go <= 1'b0;
            abort_pend <= 1'b0;
            desired    <= 12'h000;
            sq         <= 4'h0;
            ff_move    <= 1'b0;
            line_cnt   <= 5'd0;
            ir_sync    <= 3'b000;
        end else begin
            state      <= state_nxt;
            frwrd      <= frwrd_nxt;
            clr_q      <= abort_in | push;
            send_q     <= send_nxt;
            resp_q     <= resp_nxt;
            strt_cal   <= strt_nxt;
            tour_go    <= tour_nxt;
            fanfare_go <= fan_nxt;
            ir_sync    <= {ir_sync[1:0], cntrIR};
            // a fresh abort outranks the clear of the one being answered
            if (abort_in)
                abort_pend <= 1'b1;
            else if (clr_pend)
                abort_pend <= 1'b0;
            if (start_move) begin
                desired  <= (head[11:4] == 8'h00) ? 12'h000 : {head[11:4], 4'hF};
                sq       <= head[3:0];
                ff_move  <= (head[15:12] == OP_MOVE_FF);
                line_cnt <= 5'd0;
            end else if (counting && ir_rise && line_cnt != 5'h1F) begin
                line_cnt <= line_cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_cmd_proc_q.sv
// Directed bench for cmd_proc_q: stimulus queues expected events, a negedge monitor retires them.
module tb_cmd_proc_q;
    import cmd_proc_q_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cal_done, heading_rdy, lftIR, rghtIR, cntrIR;
    logic [11:0] heading;
    logic        strt_cal, moving, tour_go, fanfare_go;
    logic [11:0] error;
    logic [9:0]  frwrd;
    logic [2:0]  q_count;

    cmd_proc_q_if bus();

    cmd_proc_q dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart        (bus),
        .strt_cal    (strt_cal),
        .cal_done    (cal_done),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .lftIR       (lftIR),
        .rghtIR      (rghtIR),
        .cntrIR      (cntrIR),
        .error       (error),
        .frwrd       (frwrd),
        .moving      (moving),
        .tour_go     (tour_go),
        .fanfare_go  (fanfare_go),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum logic [1:0] {EV_RESP, EV_CAL, EV_TOUR, EV_FAN} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [7:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %h, expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                n_fail++;
                $display("FAIL event: got kind %0d val %h, expected kind %0d val %h", k, v, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (strt_cal)      observe(EV_CAL, 8'h00);
            if (tour_go)       observe(EV_TOUR, 8'h00);
            if (fanfare_go)    observe(EV_FAN, 8'h00);
            if (bus.send_resp) observe(EV_RESP, bus.resp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] c, input string name);
        logic got;
        got = 1'b0;
        bus.cmd     = c;
        bus.cmd_rdy = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(1);
            got = bus.clr_cmd_rdy;
        end
        bus.cmd_rdy = 1'b0;
        check(name, {31'd0, got}, 32'd1);
    endtask

    task automatic hdg(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            heading_rdy = 1'b1;
            tick(1);
            heading_rdy = 1'b0;
        end
    endtask

    task automatic wait_moving(input logic v, input string name);
        for (int i = 0; i < 50 && moving !== v; i++) tick(1);
        check(name, {31'd0, moving}, {31'd0, v});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw, got;
        bus.cmd = 16'h0000; bus.cmd_rdy = 1'b0;
        cal_done = 1'b0; heading = 12'h000; heading_rdy = 1'b0;
        lftIR = 1'b0; rghtIR = 1'b0; cntrIR = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("rst_frwrd", frwrd, 0);
        check("rst_moving", moving, 0);
        check("rst_q_count", q_count, 0);
        check("rst_resp", {bus.send_resp, bus.resp}, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        tick(2);

        // calibrate
        expect_ev(EV_CAL, 8'h00);
        expect_ev(EV_RESP, ACK);
        send_cmd(16'h0000, "cal_accept");
        for (int i = 0; i < 20 && !strt_cal; i++) tick(1);
        tick(2);
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        tick(3);
        check("cal_q_count", q_count, 0);

        // move with one square, aligned heading
        expect_ev(EV_RESP, ACK);
        send_cmd(16'h2001, "move_accept");
        wait_moving(1'b1, "move_moving");
        hdg(1);
        hdg(9);
        check("ramp_9", frwrd, 10'h120);
        hdg(15);
        check("ramp_24", frwrd, 10'h300);
        cntrIR = 1'b1; tick(1000); cntrIR = 1'b0;
        tick(4);
        hdg(3);
        check("long_ir_hold", frwrd, 10'h300);
        cntrIR = 1'b1; tick(1); cntrIR = 1'b0;
        tick(6);
        hdg(1);
        check("decel_1", frwrd, 10'h2C0);
        hdg(11);
        check("decel_end", frwrd, 10'h000);
        wait_moving(1'b0, "move_done");

        // IR nudge and saturation, desired = 0
        lftIR = 1'b1; tick(1000);
        check("nudge_left", error, 12'h05F);
        lftIR = 1'b0; rghtIR = 1'b1; tick(2);
        check("nudge_right", error, 12'hFA1);
        lftIR = 1'b1; tick(2);
        check("nudge_both", error, 12'h000);
        rghtIR = 1'b0; heading = 12'h7F0; tick(2);
        check("sat_pos", error, 12'h7FF);
        lftIR = 1'b0; rghtIR = 1'b1; heading = 12'h800; tick(2);
        check("sat_neg", error, 12'h800);
        rghtIR = 1'b0; heading = 12'h000; tick(2);

        // move-with-fanfare to desired 0x01F, aborted in cruise with two queued
        send_cmd(16'h3011, "ff_accept");
        wait_moving(1'b1, "ff_moving");
        heading = 12'h04F; tick(1);
        hdg(1);
        heading = 12'h030; tick(1);
        check("err_desired", error, 12'h011);
        hdg(1);
        hdg(1);
        check("align_thr", frwrd, 10'h020);
        hdg(23);
        check("abort_cruise", frwrd, 10'h300);
        send_cmd(16'h2000, "q1_accept");
        send_cmd(16'h2000, "q2_accept");
        tick(1);
        check("abort_q_before", q_count, 2);
        expect_ev(EV_RESP, ABORTED);
        send_cmd(16'hF000, "abort_accept");
        tick(1);
        check("abort_flush", q_count, 0);
        hdg(12);
        check("abort_decel", frwrd, 10'h000);
        wait_moving(1'b0, "abort_stop");
        heading = 12'h000;
        tick(3);

        // NACK, tour, fanfare on a zero-square move
        expect_ev(EV_RESP, NACK);
        expect_ev(EV_TOUR, 8'h00);
        send_cmd(16'h7000, "nack_accept");
        send_cmd(16'h4000, "tour_accept");
        expect_ev(EV_FAN, 8'h00);
        expect_ev(EV_RESP, ACK);
        send_cmd(16'h3000, "fan_accept");
        tick(10);

        // backpressure while calibrating
        expect_ev(EV_CAL, 8'h00);
        expect_ev(EV_RESP, ACK);
        send_cmd(16'h0000, "bp_cal_accept");
        tick(3);
        for (int i = 0; i < 4; i++) begin
            expect_ev(EV_RESP, ACK);
            send_cmd(16'h2000, "bp_accept");
        end
        tick(1);
        check("bp_q_count", q_count, 4);
        expect_ev(EV_RESP, ACK);
        bus.cmd = 16'h2000; bus.cmd_rdy = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.clr_cmd_rdy) saw = 1'b1;
        end
        check("bp_hold", {31'd0, saw}, 0);
        check("bp_q_full", q_count, 4);
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1);
            got = bus.clr_cmd_rdy;
        end
        bus.cmd_rdy = 1'b0;
        check("bp_fifth", {31'd0, got}, 1);
        tick(60);
        check("bp_drain", q_count, 0);

        // asynchronous reset in the middle of a ramp
        send_cmd(16'h2001, "rst_move_accept");
        wait_moving(1'b1, "rst_move_moving");
        hdg(1);
        hdg(4);
        check("pre_reset", frwrd, 10'h080);
        send_cmd(16'h2000, "rst_q_accept");
        #2 rst_n = 1'b0;
        #1;
        check("reset_frwrd", frwrd, 0);
        check("reset_q", q_count, 0);
        check("reset_moving", moving, 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);

        check("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
